// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_arbiter
// Purpose  : Round-robin arbiter that shares one WIDTH-bit register bank among
//            N requesters. Each requester posts a command (NOP/LOAD/CLEAR/SET)
//            with a req/ack handshake. One requester is granted at a time, and
//            its command is applied to the bank on the closing edge of GRANT.
// Ports    : clk      - rising-edge clock
//            reset_n  - asynchronous active-low reset
//            req      - per-requester request, held high until ack [N]
//            cmd      - per-requester command, slice i = cmd[2i+1:2i]  [2N]
//                       00 NOP, 01 LOAD, 10 CLEAR, 11 SET
//            data     - per-requester load data, slice i = data[WIDTH*i +: WIDTH]
//            grant    - one-hot grant, zero when idle [N]
//            ack      - one-cycle commit pulse to the granted requester [N]
//            q        - register bank contents [WIDTH]
//            busy     - high while in GRANT
// Revision : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       req,
    input  logic [2*N-1:0]     cmd,
    input  logic [WIDTH*N-1:0] data,
    output logic [N-1:0]       grant,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   q,
    output logic               busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    localparam logic [1:0] c_CMD_NOP   = 2'b00;
    localparam logic [1:0] c_CMD_LOAD  = 2'b01;
    localparam logic [1:0] c_CMD_CLEAR = 2'b10;
    localparam logic [1:0] c_CMD_SET   = 2'b11;

    localparam logic [N-1:0]       c_ONE_HOT0 = N'(1);
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(N - 1);
    localparam logic [c_PTR_W:0]   c_N_EXT    = (c_PTR_W + 1)'(N);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_gidx;      // index of the requester currently granted
    logic [N-1:0]       r_grant;
    logic [N-1:0]       r_ack;
    logic [WIDTH-1:0]   r_q;
    logic               r_busy;

    // ------------------------------------------------------------------------
    // Next-value wires
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic [c_PTR_W-1:0] w_gidx_nxt;
    logic [N-1:0]       w_grant_nxt;
    logic [N-1:0]       w_ack_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_busy_nxt;

    // Arbitration result
    logic               w_any;
    logic [c_PTR_W-1:0] w_pick;
    logic [c_PTR_W:0]   w_sum;

    // Granted requester's command and data
    logic [1:0]         w_sel_cmd;
    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_req;

    // ------------------------------------------------------------------------
    // Rotating-priority search: first set req bit at or after r_ptr (mod N).
    // The sum is one bit wider than the pointer so that ptr+k never overflows
    // before the modulo correction, which keeps non-power-of-two N correct.
    // ------------------------------------------------------------------------
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (c_PTR_W + 1)'(k);
            if (w_sum >= c_N_EXT) begin
                w_sum = w_sum - c_N_EXT;
            end
            if (!w_any && req[w_sum[c_PTR_W-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[c_PTR_W-1:0];
            end
        end
    end

    // Slices belonging to the granted requester, only meaningful in GRANT.
    always_comb begin
        w_sel_req  = req[r_gidx];
        w_sel_cmd  = cmd[{r_gidx, 1'b0} +: 2];
        w_sel_data = data[int'(r_gidx) * WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = c_ST_GRANT;
                end
            end
            c_ST_GRANT: begin
                // Commit or abort, GRANT always lasts exactly one cycle.
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output / datapath next values.
    // All outputs are registered, so this computes what they become at the
    // next edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant_nxt = '0;
        w_ack_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_q_nxt     = r_q;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = c_ONE_HOT0 << w_pick;
                    w_busy_nxt  = 1'b1;
                    w_gidx_nxt  = w_pick;
                end
            end
            c_ST_GRANT: begin
                // A requester that dropped req while granted has withdrawn:
                // the bank, pointer and ack are left untouched.
                if (w_sel_req) begin
                    case (w_sel_cmd)
                        c_CMD_LOAD:  w_q_nxt = w_sel_data;
                        c_CMD_CLEAR: w_q_nxt = '0;
                        c_CMD_SET:   w_q_nxt = '1;
                        c_CMD_NOP:   w_q_nxt = r_q;
                        default:     w_q_nxt = r_q;
                    endcase
                    w_ack_nxt = c_ONE_HOT0 << r_gidx;
                    // Served requester drops to lowest priority.
                    w_ptr_nxt = (r_gidx == c_LAST_IDX) ? '0 : r_gidx + 1'b1;
                end
            end
            default: begin
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output and bank registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
            r_ptr   <= '0;
            r_gidx  <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_q     <= w_q_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gidx  <= w_gidx_nxt;
        end
    end

    assign grant = r_grant;
    assign ack   = r_ack;
    assign q     = r_q;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_bank_arbiter
// Purpose  : Self-checking bench for dff_bank_arbiter (N=4, WIDTH=8).
//            A cycle-by-cycle vector table drives req/cmd/data and lists the
//            outputs expected in the same cycle; a hand-written sequence
//            covers asynchronous reset in the middle of a GRANT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

    localparam int c_N     = 4;
    localparam int c_WIDTH = 8;

    logic                   clk;
    logic                   reset_n;
    logic [c_N-1:0]         req;
    logic [2*c_N-1:0]       cmd;
    logic [c_WIDTH*c_N-1:0] data;
    logic [c_N-1:0]         grant;
    logic [c_N-1:0]         ack;
    logic [c_WIDTH-1:0]     q;
    logic                   busy;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [3:0]  e_grant;
        logic [3:0]  e_ack;
        logic [7:0]  e_q;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    dff_bank_arbiter #(
        .N     (c_N),
        .WIDTH (c_WIDTH)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .cmd     (cmd),
        .data    (data),
        .grant   (grant),
        .ack     (ack),
        .q       (q),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [7:0] c, input logic [31:0] d,
                       input logic [3:0] g, input logic [3:0] a, input logic [7:0] eq,
                       input logic b);
        vec_t v;
        v.req = r; v.cmd = c; v.data = d;
        v.e_grant = g; v.e_ack = a; v.e_q = eq; v.e_busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        req     = '0;
        cmd     = '0;
        data    = '0;

        //   req      cmd    data          grant    ack      q      busy
        // Single LOAD by requester 2
        add(4'b0100, 8'h10, 32'h003C0000, 4'b0000, 4'b0000, 8'h00, 1'b0); // c0
        add(4'b0100, 8'h10, 32'h003C0000, 4'b0100, 4'b0000, 8'h00, 1'b1); // c1
        add(4'b0000, 8'h00, 32'h00000000, 4'b0000, 4'b0100, 8'h3C, 1'b0); // c2
        // SET by 0, then CLEAR by 1
        add(4'b0001, 8'h03, 32'h00000000, 4'b0000, 4'b0000, 8'h3C, 1'b0); // c3
        add(4'b0001, 8'h03, 32'h00000000, 4'b0001, 4'b0000, 8'h3C, 1'b1); // c4
        add(4'b0010, 8'h08, 32'h00000000, 4'b0000, 4'b0001, 8'hFF, 1'b0); // c5
        add(4'b0010, 8'h08, 32'h00000000, 4'b0010, 4'b0000, 8'hFF, 1'b1); // c6
        add(4'b0000, 8'h00, 32'h00000000, 4'b0000, 4'b0010, 8'h00, 1'b0); // c7
        // Abort: 3 granted, withdraws during GRANT
        add(4'b1000, 8'h40, 32'h77000000, 4'b0000, 4'b0000, 8'h00, 1'b0); // c8
        add(4'b0000, 8'h40, 32'h77000000, 4'b1000, 4'b0000, 8'h00, 1'b1); // c9
        add(4'b0000, 8'h00, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 1'b0); // c10
        // ptr still 2: req 0110 must pick 2, then 1 (req2 held in ack cycle)
        add(4'b0110, 8'h14, 32'h00221100, 4'b0000, 4'b0000, 8'h00, 1'b0); // c11
        add(4'b0110, 8'h14, 32'h00221100, 4'b0100, 4'b0000, 8'h00, 1'b1); // c12
        add(4'b0110, 8'h14, 32'h00221100, 4'b0000, 4'b0100, 8'h22, 1'b0); // c13
        add(4'b0010, 8'h14, 32'h00221100, 4'b0010, 4'b0000, 8'h22, 1'b1); // c14
        add(4'b0000, 8'h00, 32'h00000000, 4'b0000, 4'b0010, 8'h11, 1'b0); // c15
        // NOP by 2 moves ptr to 3
        add(4'b0100, 8'h00, 32'h00FF0000, 4'b0000, 4'b0000, 8'h11, 1'b0); // c16
        add(4'b0100, 8'h00, 32'h00FF0000, 4'b0100, 4'b0000, 8'h11, 1'b1); // c17
        // Wrap: ptr=3, req 1001 -> 3 (SET) then 0 (CLEAR)
        add(4'b1001, 8'hC2, 32'h00000000, 4'b0000, 4'b0100, 8'h11, 1'b0); // c18
        add(4'b1001, 8'hC2, 32'h00000000, 4'b1000, 4'b0000, 8'h11, 1'b1); // c19
        add(4'b1001, 8'hC2, 32'h00000000, 4'b0000, 4'b1000, 8'hFF, 1'b0); // c20
        add(4'b0001, 8'hC2, 32'h00000000, 4'b0001, 4'b0000, 8'hFF, 1'b1); // c21
        add(4'b0000, 8'h00, 32'h00000000, 4'b0000, 4'b0001, 8'h00, 1'b0); // c22
        // ptr=1: req 1001 picks 3, leaving ptr=0
        add(4'b1001, 8'h40, 32'h5A000000, 4'b0000, 4'b0000, 8'h00, 1'b0); // c23
        add(4'b1001, 8'h40, 32'h5A000000, 4'b1000, 4'b0000, 8'h00, 1'b1); // c24
        // All requesting LOAD from ptr=0: order 0,1,2,3,0
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0000, 4'b1000, 8'h5A, 1'b0); // c25
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0001, 4'b0000, 8'h5A, 1'b1); // c26
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0000, 4'b0001, 8'hA0, 1'b0); // c27
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0010, 4'b0000, 8'hA0, 1'b1); // c28
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0000, 4'b0010, 8'hB1, 1'b0); // c29
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0100, 4'b0000, 8'hB1, 1'b1); // c30
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0000, 4'b0100, 8'hC2, 1'b0); // c31
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b1000, 4'b0000, 8'hC2, 1'b1); // c32
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0000, 4'b1000, 8'hD3, 1'b0); // c33
        add(4'b1111, 8'h55, 32'hD3C2B1A0, 4'b0001, 4'b0000, 8'hD3, 1'b1); // c34
        add(4'b0000, 8'h00, 32'h00000000, 4'b0000, 4'b0001, 8'hA0, 1'b0); // c35
        add(4'b0000, 8'h00, 32'h00000000, 4'b0000, 4'b0000, 8'hA0, 1'b0); // c36

        // Reset state
        #1;
        check("reset_q",     32'(q),     32'h0);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_ack",   32'(ack),   32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Table: drive inputs for the cycle, check outputs mid-cycle
        for (int i = 0; i < vecs.size(); i++) begin
            req  = vecs[i].req;
            cmd  = vecs[i].cmd;
            data = vecs[i].data;
            #1;
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            check($sformatf("v%0d_ack",   i), 32'(ack),   32'(vecs[i].e_ack));
            check($sformatf("v%0d_q",     i), 32'(q),     32'(vecs[i].e_q));
            check($sformatf("v%0d_busy",  i), 32'(busy),  32'(vecs[i].e_busy));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-GRANT with LOAD 8'hA5 pending from requester 1
        req  = 4'b0010;
        cmd  = 8'h04;
        data = 32'h0000A53B;
        @(posedge clk);
        #1;
        check("rst_pre_grant", 32'(grant), 32'h2);
        check("rst_pre_busy",  32'(busy),  32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_q",     32'(q),     32'h0);
        check("rst_async_grant", 32'(grant), 32'h0);
        check("rst_async_ack",   32'(ack),   32'h0);
        check("rst_async_busy",  32'(busy),  32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_q", 32'(q), 32'h0);
        req     = 4'b0011;
        cmd     = 8'h05;
        reset_n = 1'b1;
        // ptr reset to 0: requester 0 wins over 1
        @(posedge clk);
        #1;
        check("rst_ptr0_grant", 32'(grant), 32'h1);
        check("rst_ptr0_q",     32'(q),     32'h0);
        req = 4'b0001;
        @(posedge clk);
        #1;
        check("rst_load_ack", 32'(ack), 32'h1);
        check("rst_load_q",   32'(q),   32'h3B);
        req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 100000", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
